// File: rtl/axi_fifo_wr.sv
// AXI4 write-path buffer: queues AW and W between an upstream master and a downstream slave,
// optionally holding each address until its whole burst is buffered. B passes straight through.
module axi_fifo_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int W_DEPTH    = 32,
    parameter int AW_DEPTH   = 4,
    parameter int STORE_FWD  = 0,
    parameter int CW         = $clog2(W_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [CW-1:0]         w_count
);

    // Handshakes: a transfer occurs on a rising edge where valid && ready; a valid, once
    // raised, holds with stable payload until that edge, and ready never depends on valid.

    localparam int WA = $clog2(W_DEPTH);
    localparam int AA = $clog2(AW_DEPTH);
    localparam int WE = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int AE = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

    logic [WE-1:0] w_mem  [W_DEPTH];
    logic [AE-1:0] aw_mem [AW_DEPTH];

    logic [WA:0]   w_wr_ptr, w_rd_ptr;
    logic [AA:0]   aw_wr_ptr, aw_rd_ptr;
    logic [CW-1:0] w_count_q;
    logic [WA:0]   done_bursts;
    logic          aw_hold;

    logic w_full, w_empty, aw_full, aw_empty;
    logic s_w_hs, m_w_hs, s_aw_hs, m_aw_hs;
    logic burst_in, burst_out, aw_release;
    logic [WE-1:0] w_head;
    logic [AE-1:0] aw_head;

    assign w_full   = (w_wr_ptr[WA] != w_rd_ptr[WA]) && (w_wr_ptr[WA-1:0] == w_rd_ptr[WA-1:0]);
    assign w_empty  = (w_wr_ptr == w_rd_ptr);
    assign aw_full  = (aw_wr_ptr[AA] != aw_rd_ptr[AA]) && (aw_wr_ptr[AA-1:0] == aw_rd_ptr[AA-1:0]);
    assign aw_empty = (aw_wr_ptr == aw_rd_ptr);

    assign s_axi_wready  = !reset && !w_full;
    assign s_axi_awready = !reset && !aw_full;
    assign m_axi_wvalid  = !reset && !w_empty;

    // Cut-through escape: a full W FIFO releases the head address so bursts longer than
    // the FIFO can drain; aw_hold keeps valid asserted if that release condition lapses.
    assign aw_release    = (STORE_FWD == 0) || (done_bursts != '0) || w_full || aw_hold;
    assign m_axi_awvalid = !reset && !aw_empty && aw_release;

    assign s_w_hs  = s_axi_wvalid && s_axi_wready;
    assign m_w_hs  = m_axi_wvalid && m_axi_wready;
    assign s_aw_hs = s_axi_awvalid && s_axi_awready;
    assign m_aw_hs = m_axi_awvalid && m_axi_awready;

    assign burst_in  = s_w_hs && s_axi_wlast;
    assign burst_out = m_aw_hs;

    assign w_head  = w_mem[w_rd_ptr[WA-1:0]];
    assign aw_head = aw_mem[aw_rd_ptr[AA-1:0]];

    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_head;
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} = aw_head;

    assign w_count = w_count_q;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    always_ff @(posedge clk) begin
        if (s_w_hs) begin
            w_mem[w_wr_ptr[WA-1:0]] <= {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
        end
        if (s_aw_hs) begin
            aw_mem[aw_wr_ptr[AA-1:0]] <= {s_axi_awid, s_axi_awaddr, s_axi_awlen,
                                          s_axi_awsize, s_axi_awburst};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_wr_ptr  <= '0;
            w_rd_ptr  <= '0;
            aw_wr_ptr <= '0;
            aw_rd_ptr <= '0;
            w_count_q <= '0;
            aw_hold   <= 1'b0;
        end else begin
            if (s_w_hs)  w_wr_ptr  <= w_wr_ptr + 1'b1;
            if (m_w_hs)  w_rd_ptr  <= w_rd_ptr + 1'b1;
            if (s_aw_hs) aw_wr_ptr <= aw_wr_ptr + 1'b1;
            if (m_aw_hs) aw_rd_ptr <= aw_rd_ptr + 1'b1;
            if (s_w_hs && !m_w_hs) begin
                w_count_q <= w_count_q + 1'b1;
            end else if (m_w_hs && !s_w_hs) begin
                w_count_q <= w_count_q - 1'b1;
            end
            aw_hold <= m_axi_awvalid && !m_axi_awready;
        end
    end

    // Completed bursts sitting in the W FIFO whose address has not yet been released.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_bursts <= '0;
        end else if (burst_in && !burst_out) begin
            if (done_bursts != '1) done_bursts <= done_bursts + 1'b1;
        end else if (burst_out && !burst_in) begin
            if (done_bursts != '0) done_bursts <= done_bursts - 1'b1;
        end
    end

endmodule
